// File: rtl/k_alu_arbiter_if.sv
// Request/grant and ALU bus bundle for k_alu_arbiter.
// Slave modport is the arbiter side; master is the requester plus ALU side.
`timescale 1ns/1ps
interface k_alu_arbiter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = 3
);
   logic [2:0]          req;
   logic [3*DATA_W-1:0] req_opa;
   logic [3*DATA_W-1:0] req_opb;
   logic [3*SEL_W-1:0]  req_sel;
   logic [2:0]          gnt;
   logic [2:0]          done;
   logic [DATA_W-1:0]   result_out;
   logic                busy;
   logic [DATA_W-1:0]   alu_opA;
   logic [DATA_W-1:0]   alu_opB;
   logic [SEL_W-1:0]    alu_selector;
   logic                alu_enable;
   logic                alu_write_enable;
   logic [DATA_W-1:0]   alu_result;

   modport slave (
      input  req, req_opa, req_opb, req_sel, alu_result,
      output gnt, done, result_out, busy,
      output alu_opA, alu_opB, alu_selector, alu_enable, alu_write_enable
   );

   modport master (
      output req, req_opa, req_opb, req_sel, alu_result,
      input  gnt, done, result_out, busy,
      input  alu_opA, alu_opB, alu_selector, alu_enable, alu_write_enable
   );
endinterface

// File: rtl/k_alu_arbiter.sv
// Round-robin arbiter sharing one K_ALU between R/G/B requesters.
// Optional per-channel grant counters when K_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module k_alu_arbiter #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
`ifdef K_ARB_STATS_EN
   input  logic              stats_clr,
   output logic [3*16-1:0]   grant_cnt,
`endif
   k_alu_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   localparam logic [3:0] LatCnt = 4'(ALU_LAT);

   state_e              state_q, state_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [1:0]          win_q, win_d;
   logic [2:0]          mask_q, mask_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [2:0]          gnt_q, gnt_d;
   logic [2:0]          done_q, done_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                en_q, en_d;

   logic [2:0]          eff;
   logic [2:0]          sum;
   logic [1:0]          cand;
   logic [1:0]          pick;
   logic                found;

   // First requesting channel at or after the rr pointer, wrapping mod 3.
   always_comb begin
      eff   = bus.req & ~mask_q;
      pick  = ptr_q;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < 3; i++) begin
         sum  = 3'(ptr_q) + 3'(i);
         cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
         if (!found && eff[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      res_d   = res_q;
      en_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            mask_d = '0;
            if (found) begin
               win_d   = pick;
               opa_d   = bus.req_opa[pick*DATA_W +: DATA_W];
               opb_d   = bus.req_opb[pick*DATA_W +: DATA_W];
               sel_d   = bus.req_sel[pick*SEL_W +: SEL_W];
               gnt_d   = 3'b001 << pick;
               en_d    = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = 4'd1;
            state_d = StWait;
         end
         StWait: begin
            if (cnt_q == LatCnt) begin
               res_d   = bus.alu_result;
               done_d  = 3'b001 << win_q;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDone: begin
            ptr_d   = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
            mask_d  = 3'b001 << win_q;
            gnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         win_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         res_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         res_q   <= res_d;
         en_q    <= en_d;
      end
   end

   assign bus.gnt              = gnt_q;
   assign bus.done             = done_q;
   assign bus.result_out       = res_q;
   assign bus.busy             = (state_q != StIdle);
   assign bus.alu_opA          = opa_q;
   assign bus.alu_opB          = opb_q;
   assign bus.alu_selector     = sel_q;
   assign bus.alu_enable       = en_q;
   assign bus.alu_write_enable = en_q;

`ifdef K_ARB_STATS_EN
   logic [2:0][15:0] stat_q, stat_d;

   // Clear has priority over a coincident increment; counts saturate.
   always_comb begin
      stat_d = stat_q;
      if (stats_clr) begin
         stat_d = '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (done_q[i] && (stat_q[i] != 16'hFFFF)) begin
               stat_d[i] = stat_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign grant_cnt = stat_q;
`else
   // Grant statistics are compiled out in this build.
`endif

endmodule

// File: tb/tb_k_alu_arbiter.sv
// Directed self-checking bench for k_alu_arbiter (ALU_LAT=1 and ALU_LAT=4 instances).
// Exercises K_ARB_STATS_EN counters when that macro is defined.
`timescale 1ns/1ps
module tb_k_alu_arbiter;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   k_alu_arbiter_if #(.DATA_W(8), .SEL_W(3)) i1 ();
   k_alu_arbiter_if #(.DATA_W(8), .SEL_W(3)) i4 ();

`ifdef K_ARB_STATS_EN
   logic        stats_clr;
   logic        stats_clr4;
   logic [47:0] grant_cnt1;
   logic [47:0] grant_cnt4;
`endif

   k_alu_arbiter #(.DATA_W(8), .SEL_W(3), .ALU_LAT(1)) u1 (
      .clk       (clk),
      .reset     (reset),
`ifdef K_ARB_STATS_EN
      .stats_clr (stats_clr),
      .grant_cnt (grant_cnt1),
`endif
      .bus       (i1.slave)
   );

   k_alu_arbiter #(.DATA_W(8), .SEL_W(3), .ALU_LAT(4)) u4 (
      .clk       (clk),
      .reset     (reset),
`ifdef K_ARB_STATS_EN
      .stats_clr (stats_clr4),
      .grant_cnt (grant_cnt4),
`endif
      .bus       (i4.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s);
      case (s)
         3'd0:    alu_f = a + b;
         3'd1:    alu_f = a - b;
         3'd2:    alu_f = a & b;
         3'd3:    alu_f = a | b;
         3'd4:    alu_f = a ^ b;
         default: alu_f = 8'h00;
      endcase
   endfunction

   // ALU model: result valid only exactly ALU_LAT cycles after the launch strobe.
   logic [3:0] age1, age4;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         age1 <= '0;
         age4 <= '0;
      end else begin
         if (i1.alu_enable && i1.alu_write_enable) age1 <= 4'd1;
         else if (age1 != 4'd0 && age1 != 4'hF) age1 <= age1 + 4'd1;
         if (i4.alu_enable && i4.alu_write_enable) age4 <= 4'd1;
         else if (age4 != 4'd0 && age4 != 4'hF) age4 <= age4 + 4'd1;
      end
   end
   assign i1.alu_result = (age1 == 4'd1) ? alu_f(i1.alu_opA, i1.alu_opB, i1.alu_selector)
                                         : 8'hEE;
   assign i4.alu_result = (age4 == 4'd4) ? alu_f(i4.alu_opA, i4.alu_opB, i4.alu_selector)
                                         : 8'hEE;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      i1.req = '0;
      i4.req = '0;
      tick();
      reset  = 1'b1;
   endtask

`ifdef K_ARB_STATS_EN
   task automatic run_one(input int ch, input logic [7:0] a, input logic [7:0] b);
      logic seen;
      seen = 1'b0;
      i1.req_opa[ch*8 +: 8] = a;
      i1.req_opb[ch*8 +: 8] = b;
      i1.req_sel[ch*3 +: 3] = 3'd0;
      i1.req[ch] = 1'b1;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (i1.done[ch]) seen = 1'b1;
      end
      chk("stats_done_seen", 48'(seen), 48'd1);
      i1.req[ch] = 1'b0;
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] exp_d, exp_g, reraise;
      n_cmp = 0;
      n_bad = 0;
      clk = 1'b0;
      reset = 1'b0;
      i1.req = '0; i1.req_opa = '0; i1.req_opb = '0; i1.req_sel = '0;
      i4.req = '0; i4.req_opa = '0; i4.req_opb = '0; i4.req_sel = '0;
`ifdef K_ARB_STATS_EN
      stats_clr = 1'b0;
      stats_clr4 = 1'b0;
`endif
      #1;
      chk("rst_gnt", 48'(i1.gnt), 48'd0);
      chk("rst_done", 48'(i1.done), 48'd0);
      chk("rst_busy", 48'(i1.busy), 48'd0);
      chk("rst_result", 48'(i1.result_out), 48'd0);
      chk("rst_alu", 48'({i1.alu_opA, i1.alu_opB, i1.alu_selector, i1.alu_enable,
                          i1.alu_write_enable}), 48'd0);
      tick();
      reset = 1'b1;

      // Single R request: 5 + 3.
      i1.req_opa[7:0] = 8'd5; i1.req_opb[7:0] = 8'd3; i1.req_sel[2:0] = 3'd0;
      i1.req = 3'b001;
      tick();
      chk("t1_en", 48'(i1.alu_enable), 48'd1);
      chk("t1_we", 48'(i1.alu_write_enable), 48'd1);
      chk("t1_gnt", 48'(i1.gnt), 48'd1);
      chk("t1_busy", 48'(i1.busy), 48'd1);
      chk("t1_opa", 48'(i1.alu_opA), 48'd5);
      tick();
      chk("t1_en_wait", 48'(i1.alu_enable), 48'd0);
      chk("t1_done_early", 48'(i1.done), 48'd0);
      tick();
      chk("t1_done", 48'(i1.done), 48'd1);
      chk("t1_result", 48'(i1.result_out), 48'd8);
      i1.req = '0;
      tick();
      chk("t1_done_pulse", 48'(i1.done), 48'd0);
      chk("t1_idle", 48'(i1.busy), 48'd0);
      chk("t1_hold", 48'(i1.result_out), 48'd8);

      // All three at once: R, G, B served at 3, 7, 11.
      do_reset();
      i1.req_opa = {8'hF0, 8'd10, 8'd5};
      i1.req_opb = {8'h3C, 8'd4, 8'd3};
      i1.req_sel = {3'd2, 3'd1, 3'd0};
      i1.req = 3'b111;
      for (int c = 1; c <= 12; c++) begin
         tick();
         exp_d = (c == 3) ? 3'b001 : (c == 7) ? 3'b010 : (c == 11) ? 3'b100 : 3'b000;
         exp_g = (c >= 1 && c <= 3) ? 3'b001 : (c >= 5 && c <= 7) ? 3'b010 :
                 (c >= 9 && c <= 11) ? 3'b100 : 3'b000;
         chk("t2_done", 48'(i1.done), 48'(exp_d));
         chk("t2_gnt", 48'(i1.gnt), 48'(exp_g));
         if (c == 3)  chk("t2_res_r", 48'(i1.result_out), 48'h08);
         if (c == 7)  chk("t2_res_g", 48'(i1.result_out), 48'h06);
         if (c == 11) chk("t2_res_b", 48'(i1.result_out), 48'h30);
         i1.req = i1.req & ~i1.done;
      end

      // Fairness: R and G re-raise the cycle after their own done.
      do_reset();
      i1.req = 3'b011;
      reraise = '0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         exp_d = (c == 3 || c == 11) ? 3'b001 : (c == 7 || c == 15) ? 3'b010 : 3'b000;
         exp_g = ((c >= 1 && c <= 3) || (c >= 9 && c <= 11)) ? 3'b001 :
                 ((c >= 5 && c <= 7) || (c >= 13 && c <= 15)) ? 3'b010 : 3'b000;
         chk("t3_done", 48'(i1.done), 48'(exp_d));
         chk("t3_gnt", 48'(i1.gnt), 48'(exp_g));
         i1.req  = (i1.req | reraise) & ~i1.done;
         reraise = i1.done;
      end
      i1.req = '0;

      // Mask: lone R re-raising right after done must skip one IDLE cycle.
      do_reset();
      i1.req = 3'b001;
      tick(); tick(); tick();
      chk("t3m_done", 48'(i1.done), 48'd1);
      i1.req = '0;
      tick();
      i1.req = 3'b001;
      tick();
      chk("t3m_masked_en", 48'(i1.alu_enable), 48'd0);
      chk("t3m_masked_gnt", 48'(i1.gnt), 48'd0);
      tick();
      chk("t3m_en", 48'(i1.alu_enable), 48'd1);
      chk("t3m_gnt", 48'(i1.gnt), 48'd1);
      tick(); tick();
      chk("t3m_done2", 48'(i1.done), 48'd1);
      i1.req = '0;
      tick();

      // ALU_LAT=4 instance: 7 ^ 9 = 14, operand change after grant ignored.
      i4.req_opa[7:0] = 8'd7; i4.req_opb[7:0] = 8'd9; i4.req_sel[2:0] = 3'd4;
      i4.req = 3'b001;
      for (int c = 1; c <= 7; c++) begin
         tick();
         chk("t4_en", 48'(i4.alu_enable), (c == 1) ? 48'd1 : 48'd0);
         if (c <= 5) chk("t4_opa_stable", 48'(i4.alu_opA), 48'd7);
         chk("t4_done", 48'(i4.done), (c == 6) ? 48'd1 : 48'd0);
         chk("t4_result", 48'(i4.result_out), (c >= 6) ? 48'd14 : 48'd0);
         if (c == 2) i4.req_opa[7:0] = 8'hFF;
         if (c == 6) i4.req = '0;
      end

      // Reset during WAIT aborts B; pending G then wins from pointer 0.
      do_reset();
      i1.req_opa[23:16] = 8'h11; i1.req_opb[23:16] = 8'h01; i1.req_sel[8:6] = 3'd0;
      i1.req = 3'b100;
      tick();
      tick();
      chk("t5_pre_opa", 48'(i1.alu_opA), 48'h11);
      chk("t5_pre_gnt", 48'(i1.gnt), 48'd4);
      reset = 1'b0;
      #1;
      chk("t5_rst_gnt", 48'(i1.gnt), 48'd0);
      chk("t5_rst_busy", 48'(i1.busy), 48'd0);
      chk("t5_rst_alu", 48'({i1.alu_opA, i1.alu_opB, i1.alu_selector, i1.alu_enable}), 48'd0);
      chk("t5_rst_done", 48'(i1.done), 48'd0);
      i1.req = 3'b010;
      i1.req_opa[15:8] = 8'h20; i1.req_opb[15:8] = 8'h05; i1.req_sel[5:3] = 3'd0;
      tick();
      chk("t5_no_done", 48'(i1.done), 48'd0);
      reset = 1'b1;
      tick();
      chk("t5_gnt_g", 48'(i1.gnt), 48'd2);
      tick();
      chk("t5_no_done2", 48'(i1.done), 48'd0);
      tick();
      chk("t5_done_g", 48'(i1.done), 48'd2);
      chk("t5_res_g", 48'(i1.result_out), 48'h25);
      i1.req = '0;
      tick();

`ifdef K_ARB_STATS_EN
      do_reset();
      run_one(0, 8'd1, 8'd1);
      run_one(2, 8'd2, 8'd2);
      run_one(0, 8'd3, 8'd3);
      run_one(2, 8'd4, 8'd4);
      run_one(0, 8'd5, 8'd5);
      chk("t6_cnt", grant_cnt1, {16'd2, 16'd0, 16'd3});
      chk("t6_cnt4", grant_cnt4, 48'd0);
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      chk("t6_clr", grant_cnt1, 48'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
